// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_pkg
// Description : Shared constants and types for the MMIO responder: register
//               offsets inside the 32-byte window, STATUS bit positions and
//               the UART transmitter state encoding.
// Revision    : 1.0  initial release
// ============================================================================
package mmio_pkg;

    // Register offsets (address[4:0])
    localparam logic [4:0] OFF_HALT      = 5'h00;
    localparam logic [4:0] OFF_SIG_BEGIN = 5'h04;
    localparam logic [4:0] OFF_SIG_END   = 5'h08;
    localparam logic [4:0] OFF_TXDATA    = 5'h0C;
    localparam logic [4:0] OFF_STATUS    = 5'h10;

    // STATUS register bit positions
    localparam int STAT_FULL = 0;
    localparam int STAT_BUSY = 1;
    localparam int STAT_OVF  = 2;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : 8N1 serial transmitter. Accepts a byte when valid & ready,
//               then sends start bit, 8 data bits LSB first and a stop bit,
//               each lasting CLK_DIV clocks. The line output is registered
//               from the current state, so it trails the state by one clock.
// Ports       : clock, reset (sync, active-high)
//               valid, data[7:0] - byte offered by the FIFO
//               ready            - transmitter idle, byte taken when valid
//               tx               - serial line, idle high
// Revision    : 1.0  initial release
// ============================================================================
module uart_tx
    import mmio_pkg::*;
#(
    parameter int CLK_DIV = 868
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx
);

    localparam int                 c_cnt_w    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(CLK_DIV - 1);

    uart_state_t        r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [7:0]         r_shift;
    logic [2:0]         r_bit;
    logic               r_tx;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= UART_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                UART_IDLE: begin
                    r_tx <= 1'b1;
                    if (valid) begin
                        r_shift <= data;
                        r_cnt   <= c_cnt_load;
                        r_bit   <= '0;
                        r_state <= UART_START;
                    end
                end
                UART_START: begin
                    r_tx <= 1'b0;
                    if (r_cnt == '0) begin
                        r_cnt   <= c_cnt_load;
                        r_state <= UART_DATA;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end
                UART_DATA: begin
                    r_tx <= r_shift[0];
                    if (r_cnt == '0) begin
                        r_cnt <= c_cnt_load;
                        if (r_bit == 3'd7) begin
                            r_state <= UART_STOP;
                        end else begin
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_bit   <= r_bit + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end
                UART_STOP: begin
                    r_tx <= 1'b1;
                    if (r_cnt == '0) begin
                        r_state <= UART_IDLE;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end
                default: r_state <= UART_IDLE;
            endcase
        end
    end

    assign ready = (r_state == UART_IDLE);
    assign tx    = r_tx;

endmodule
`default_nettype wire

// File: rtl/mmio_dev.sv
`default_nettype none
// ============================================================================
// Module      : mmio_dev
// Description : Memory-mapped responder in a 32-byte window at BASE. Holds a
//               sticky halt flag, signature range registers and a console TX
//               FIFO drained by an 8N1 UART transmitter.
// Ports       : clock, reset (sync, active-high)
//               mem_load, mem_store, address, store_data - CPU data bus
//               load_data - combinational read data (0 when not hit)
//               hit       - address falls inside the window
//               halt, sig_begin, sig_end - register outputs
//               uart_tx   - serial line, idle high
// Revision    : 1.0  initial release
// ============================================================================
module mmio_dev
    import mmio_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] BASE       = 32'h20000000,
    parameter int              CLK_DIV    = 868,
    parameter int              FIFO_DEPTH = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            mem_load,
    input  logic            mem_store,
    input  logic [XLEN-1:0] address,
    input  logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] load_data,
    output logic            hit,
    output logic            halt,
    output logic [XLEN-1:0] sig_begin,
    output logic [XLEN-1:0] sig_end,
    output logic            uart_tx
);

    localparam int                 c_ptr_w      = $clog2(FIFO_DEPTH);
    localparam logic [c_ptr_w:0]   c_full_count = (c_ptr_w + 1)'(FIFO_DEPTH);

    logic [4:0]         w_off;
    logic               w_hit;
    logic               w_wr;
    logic               w_push_req;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_nonempty;
    logic               w_busy;
    logic               w_uart_ready;
    logic [XLEN-1:0]    w_rdata;
    logic               w_unused_load;

    logic               r_halt;
    logic [XLEN-1:0]    r_sig_begin;
    logic [XLEN-1:0]    r_sig_end;
    logic               r_overflow;
    logic [7:0]         r_fifo [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;

    // Reads have no side effects, so the load strobe is not needed.
    assign w_unused_load = mem_load;

    assign w_off      = address[4:0];
    assign w_hit      = (address[XLEN-1:5] == BASE[XLEN-1:5]);
    assign w_wr       = mem_store & w_hit;
    assign w_full     = (r_count == c_full_count);
    assign w_nonempty = (r_count != '0);
    assign w_push_req = w_wr & (w_off == OFF_TXDATA);
    // Fullness uses the pre-edge count: a same-cycle pop does not make room.
    assign w_push     = w_push_req & ~w_full;
    assign w_pop      = w_nonempty & w_uart_ready;
    assign w_busy     = ~w_uart_ready | w_nonempty;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_halt      <= 1'b0;
            r_sig_begin <= '0;
            r_sig_end   <= '0;
            r_overflow  <= 1'b0;
        end else if (w_wr) begin
            case (w_off)
                OFF_HALT:      if (store_data[0]) r_halt <= 1'b1;
                OFF_SIG_BEGIN: r_sig_begin <= store_data;
                OFF_SIG_END:   r_sig_end   <= store_data;
                OFF_TXDATA:    if (w_full) r_overflow <= 1'b1;
                OFF_STATUS:    if (store_data[STAT_OVF]) r_overflow <= 1'b0;
                default:       ;
            endcase
        end
    end

    // Storage carries no reset; pointers and count define validity.
    always_ff @(posedge clock) begin
        if (w_push) r_fifo[r_wr_ptr] <= store_data[7:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    uart_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_uart_tx (
        .clock (clock),
        .reset (reset),
        .valid (w_nonempty),
        .data  (r_fifo[r_rd_ptr]),
        .ready (w_uart_ready),
        .tx    (uart_tx)
    );

    always_comb begin
        w_rdata = '0;
        if (w_hit) begin
            case (w_off)
                OFF_HALT:      w_rdata[0] = r_halt;
                OFF_SIG_BEGIN: w_rdata = r_sig_begin;
                OFF_SIG_END:   w_rdata = r_sig_end;
                OFF_STATUS: begin
                    w_rdata[STAT_OVF]  = r_overflow;
                    w_rdata[STAT_BUSY] = w_busy;
                    w_rdata[STAT_FULL] = w_full;
                end
                default:       w_rdata = '0;
            endcase
        end
    end

    assign load_data = w_rdata;
    assign hit       = w_hit;
    assign halt      = r_halt;
    assign sig_begin = r_sig_begin;
    assign sig_end   = r_sig_end;

endmodule
`default_nettype wire

// File: tb/tb_mmio_dev.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_dev
// Description : Self-checking bench for mmio_dev. Register reads are checked
//               against a behavioural register-map model; every byte accepted
//               into the TX FIFO is queued and a serial monitor decodes each
//               frame on uart_tx and compares its full 10-bit waveform.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mmio_dev;

    localparam int          XLEN       = 32;
    localparam logic [31:0] BASE       = 32'h20000000;
    localparam int          CLK_DIV    = 4;
    localparam int          FIFO_DEPTH = 4;
    localparam int          FRAME      = 10 * CLK_DIV;

    localparam logic [4:0] A_HALT = 5'h00;
    localparam logic [4:0] A_SIGB = 5'h04;
    localparam logic [4:0] A_SIGE = 5'h08;
    localparam logic [4:0] A_TX   = 5'h0C;
    localparam logic [4:0] A_STAT = 5'h10;

    logic            clock      = 1'b0;
    logic            reset      = 1'b1;
    logic            mem_load   = 1'b0;
    logic            mem_store  = 1'b0;
    logic [XLEN-1:0] address    = '0;
    logic [XLEN-1:0] store_data = '0;
    logic [XLEN-1:0] load_data;
    logic            hit;
    logic            halt;
    logic [XLEN-1:0] sig_begin;
    logic [XLEN-1:0] sig_end;
    logic            uart_tx;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0]  exp_q[$];
    logic        m_halt      = 1'b0;
    logic [31:0] m_sig_begin = '0;
    logic [31:0] m_sig_end   = '0;
    logic        m_ovf       = 1'b0;

    mmio_dev #(
        .XLEN       (XLEN),
        .BASE       (BASE),
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .mem_load   (mem_load),
        .mem_store  (mem_store),
        .address    (address),
        .store_data (store_data),
        .load_data  (load_data),
        .hit        (hit),
        .halt       (halt),
        .sig_begin  (sig_begin),
        .sig_end    (sig_end),
        .uart_tx    (uart_tx)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] off, input logic busy, input logic full);
        case (off)
            A_HALT:  return {31'b0, m_halt};
            A_SIGB:  return m_sig_begin;
            A_SIGE:  return m_sig_end;
            A_STAT:  return {29'b0, m_ovf, busy, full};
            default: return 32'h0;
        endcase
    endfunction

    // Expected uart_tx samples, one per clock, start bit first.
    function automatic logic [FRAME-1:0] frame_of(input logic [7:0] b);
        logic [9:0]       bits;
        logic [FRAME-1:0] f;
        bits = {1'b1, b, 1'b0};
        for (int i = 0; i < FRAME; i++) f[i] = bits[i / CLK_DIV];
        return f;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        address    = a;
        store_data = d;
        mem_store  = 1'b1;
        tick();
        mem_store  = 1'b0;
        address    = '0;
    endtask

    task automatic rd_check(input logic [4:0] off, input logic [31:0] exp, input string nm);
        address  = BASE | {27'b0, off};
        mem_load = 1'b1;
        @(negedge clock);
        check(nm, load_data, exp);
        tick();
        mem_load = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        address = BASE | {27'b0, A_STAT};
        @(negedge clock);
        while (load_data[1] === 1'b1 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 2000) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: busy still %b, expected 0", load_data[1]);
        end
        tick();
        repeat (2) tick();
    endtask

    // Starting from an idle device: the first byte goes straight to the
    // transmitter, so the FIFO can absorb FIFO_DEPTH more before dropping.
    task automatic burst(input int k, input logic [7:0] first, input bit rnd);
        int         acc;
        logic [7:0] b;
        acc = 0;
        for (int i = 0; i < k; i++) begin
            b = rnd ? 8'($urandom) : first + 8'(i);
            wr(BASE | {27'b0, A_TX}, rnd ? {$urandom, b} >> 0 & 32'hFFFF_FF00 | {24'b0, b} : {24'b0, b});
            if (acc < FIFO_DEPTH + 1) begin
                exp_q.push_back(b);
                acc++;
            end else begin
                m_ovf = 1'b1;
            end
            if (rnd) repeat ($urandom_range(0, 2)) tick();
        end
        rd_check(A_STAT, {29'b0, m_ovf, 1'b1, (acc == FIFO_DEPTH + 1)}, "status_after_burst");
    endtask

    // Serial monitor: decode each frame and compare against the queue.
    initial begin
        logic             prev;
        logic             aborted;
        logic [FRAME-1:0] act;
        logic [FRAME-1:0] expf;
        logic [7:0]       eb;
        prev = 1'b1;
        forever begin
            @(negedge clock);
            if (reset !== 1'b1 && prev === 1'b1 && uart_tx === 1'b0) begin
                act     = '0;
                act[0]  = uart_tx;
                aborted = 1'b0;
                for (int i = 1; i < FRAME && !aborted; i++) begin
                    @(negedge clock);
                    if (reset === 1'b1) aborted = 1'b1;
                    act[i] = uart_tx;
                end
                prev = uart_tx;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame: got frame %h, expected none", act);
                end else begin
                    eb = exp_q.pop_front();
                    if (!aborted) begin
                        expf = frame_of(eb);
                        total++;
                        if (act !== expf) begin
                            bad++;
                            $display("FAIL uart_frame byte %h: got %h, expected %h", eb, act, expf);
                        end
                    end
                end
            end else begin
                prev = uart_tx;
            end
        end
    end

    initial begin
        int          nb;
        logic [31:0] d;
        logic [4:0]  off;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset_uart_tx", {31'b0, uart_tx}, 32'h1);
        check("reset_halt", {31'b0, halt}, 32'h0);
        check("reset_sig_begin", sig_begin, 32'h0);
        check("reset_sig_end", sig_end, 32'h0);
        for (int i = 0; i < 8; i++) rd_check(5'(i * 4), 32'h0, "reset_read");

        // HALT is sticky and only set by bit 0
        wr(BASE | A_HALT, 32'h0);
        check("halt_store0", {31'b0, halt}, 32'h0);
        wr(BASE | A_HALT, 32'h1);
        m_halt = 1'b1;
        check("halt_store1", {31'b0, halt}, 32'h1);
        wr(BASE | A_HALT, 32'h0);
        check("halt_sticky", {31'b0, halt}, 32'h1);
        rd_check(A_HALT, exp_read(A_HALT, 1'b0, 1'b0), "halt_read");

        // Signature range and window decode
        wr(BASE | A_SIGB, 32'h20001000);
        m_sig_begin = 32'h20001000;
        wr(BASE | A_SIGE, 32'h20001040);
        m_sig_end = 32'h20001040;
        check("sig_begin_out", sig_begin, m_sig_begin);
        check("sig_end_out", sig_end, m_sig_end);
        rd_check(A_SIGB, exp_read(A_SIGB, 1'b0, 1'b0), "sig_begin_read");
        rd_check(A_SIGE, exp_read(A_SIGE, 1'b0, 1'b0), "sig_end_read");
        address = 32'h20000020;
        @(negedge clock);
        check("miss_hit", {31'b0, hit}, 32'h0);
        check("miss_load_data", load_data, 32'h0);
        address = BASE | 32'h1C;
        @(negedge clock);
        check("top_of_window_hit", {31'b0, hit}, 32'h1);
        tick();
        wr(32'h20000024, 32'hDEADBEEF);
        check("miss_store_ignored", sig_begin, m_sig_begin);
        wr(BASE | 32'h14, 32'hFFFFFFFF);
        rd_check(5'h14, 32'h0, "unmapped_read");

        // Single byte 0xA5, busy across the whole frame
        wr(BASE | A_TX, 32'h000000A5);
        exp_q.push_back(8'hA5);
        nb = 0;
        address = BASE | A_STAT;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clock);
            if (load_data !== 32'h2) nb++;
        end
        check("busy_during_frame", nb, 0);
        tick();
        wait_idle();
        rd_check(A_STAT, 32'h0, "status_idle_after_a5");

        // Six back-to-back stores: sixth dropped, then clear overflow
        burst(6, 8'h01, 1'b0);
        rd_check(A_TX, 32'h0, "txdata_read_zero");
        wr(BASE | A_STAT, 32'h4);
        m_ovf = 1'b0;
        rd_check(A_STAT, {29'b0, m_ovf, 1'b1, 1'b1}, "overflow_cleared");
        wait_idle();
        rd_check(A_STAT, 32'h0, "status_idle_after_burst");

        // Randomized register traffic and bursts
        for (int it = 0; it < 10; it++) begin
            d = $urandom;
            wr(BASE | A_SIGB, d);
            m_sig_begin = d;
            d = $urandom;
            wr(BASE | A_SIGE, d);
            m_sig_end = d;
            d = $urandom;
            wr(BASE | A_HALT, d);
            m_halt = m_halt | d[0];
            off = 5'h14 + 5'($urandom_range(0, 2) * 4);
            wr(BASE | {27'b0, off}, $urandom);
            for (int r = 0; r < 3; r++) begin
                off = 5'($urandom_range(0, 31));
                if (off == A_TX) off = A_SIGB;
                rd_check(off, exp_read(off, 1'b0, 1'b0), "rand_read");
            end
            burst($urandom_range(1, 6), 8'h00, 1'b1);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                wr(BASE | A_STAT, d);
                if (d[2]) m_ovf = 1'b0;
            end
            wait_idle();
            rd_check(A_STAT, exp_read(A_STAT, 1'b0, 1'b0), "rand_status_idle");
        end

        // Reset in the middle of a frame
        wr(BASE | A_TX, 32'h0000003C);
        exp_q.push_back(8'h3C);
        repeat (15) tick();
        reset = 1'b1;
        tick();
        check("tx_after_reset", {31'b0, uart_tx}, 32'h1);
        reset = 1'b0;
        exp_q.delete();
        m_halt      = 1'b0;
        m_sig_begin = '0;
        m_sig_end   = '0;
        m_ovf       = 1'b0;
        check("halt_after_reset", {31'b0, halt}, 32'h0);
        rd_check(A_STAT, 32'h0, "status_after_reset");
        repeat (100) tick();
        rd_check(A_STAT, 32'h0, "status_quiet_after_reset");

        check("leftover_bytes", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmio_dev.md
Name: mmio_dev

Overview:
- Memory-mapped responder on the CPU data bus: decodes `mem_load`/`mem_store`/`address` within a 32-byte window at BASE and returns `load_data`.
- Provides a synthesizable halt flag and signature-range registers, plus a console TX FIFO drained by an 8N1 UART transmitter.
- Sits beside the data RAM; the top-level muxes `load_data` from this block when `hit` is 1.

Parameters:
- XLEN, 32, data/address width.
- BASE, 32'h20000000, window base address; low 5 bits are zero.
- CLK_DIV, 868, clocks per UART bit; must be >= 2.
- FIFO_DEPTH, 16, TX FIFO entries; power of 2, >= 2.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- mem_load  in  1  CPU load strobe.
- mem_store  in  1  CPU store strobe.
- address  in  XLEN  byte address.
- store_data  in  XLEN  write data.
- load_data  out  XLEN  read data; combinational from `address`.
- hit  out  1  `address[XLEN-1:5] == BASE[XLEN-1:5]`; combinational.
- halt  out  1  sticky halt flag.
- sig_begin  out  XLEN  signature start byte address.
- sig_end  out  XLEN  signature end byte address (exclusive).
- uart_tx  out  1  serial line, idle high.

Behaviour:
- Clock and reset: one clock, `clock`; `reset` is synchronous and active-high.
- Reset values: `halt`=0, `sig_begin`=0, `sig_end`=0, `uart_tx`=1, FIFO empty, overflow=0, UART FSM in IDLE.
- Reset mid-frame aborts the frame: `uart_tx` is 1 on the cycle after the reset edge.
- Register map, by offset `off = address[4:0]`:
  - 0x00 HALT: store with `store_data[0]`=1 sets `halt`; a store with 0 does not clear it (only reset clears). Read = {0…, halt}.
  - 0x04 SIG_BEGIN: R/W, full XLEN.
  - 0x08 SIG_END: R/W, full XLEN.
  - 0x0C TXDATA: a store pushes `store_data[7:0]` if count < FIFO_DEPTH. Otherwise the byte is dropped and overflow (sticky) is set. Read = 0.
  - 0x10 STATUS: read = {0…, overflow[2], busy[1], full[0]}. busy = FSM not IDLE or FIFO non-empty. A store with `store_data[2]`=1 clears overflow.
  - Other offsets: read 0; writes ignored.
- Bus timing:
  - Writes take effect at the clock edge where `mem_store`&`hit`=1.
  - `load_data` = selected register when `hit`, else 0; this is independent of `mem_load`. Reads have no side effects.
- Fullness is judged on pre-edge count: a push to a full FIFO is dropped even if the UART pops in the same cycle. Simultaneous push and pop on a non-full FIFO leaves count unchanged.
- Overflow set and clear in the same cycle cannot occur (different offsets).
- UART FSM states: IDLE, START, DATA, STOP. Baud counter counts CLK_DIV-1 down to 0; bit index is 0..7.
  - IDLE: if FIFO non-empty, pop the head into the shift register, go to START, load the counter. `uart_tx`=1.
  - START: `uart_tx`=0 for CLK_DIV cycles, then DATA.
  - DATA: `uart_tx`=shift[0], LSB first; each CLK_DIV cycles shift right. After bit 7, go to STOP.
  - STOP: `uart_tx`=1 for CLK_DIV cycles, then IDLE.
  - A frame is exactly 10×CLK_DIV cycles. Back-to-back bytes have one extra IDLE cycle between frames.
- `uart_tx` is registered; the first start-bit low appears one cycle after the pop edge.
- FIFO pointers are log2(FIFO_DEPTH) bits with natural wrap. Count is log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Package mmio_pkg:
  - Offset constants OFF_HALT, OFF_SIG_BEGIN, OFF_SIG_END, OFF_TXDATA, OFF_STATUS.
  - STATUS bit indices.
  - UART state enum (2 bits).
- Sub-module uart_tx: ports clock, reset, valid, data[7:0], ready (=IDLE), tx. The pop condition is valid&ready. The FIFO and register decode stay in mmio_dev.

Test Plan (CLK_DIV=4, FIFO_DEPTH=4):
- Reset then read all offsets → every read is 0 and `uart_tx`=1.
- Store 0x0 to HALT → `halt` stays 0. Store 0x1 → `halt`=1 next cycle. Store 0x0 → `halt` still 1.
- Store 0x20001000 to SIG_BEGIN and 0x20001040 to SIG_END → outputs and readback match. Address 0x20000020 → `hit`=0 and `load_data`=0.
- Store 0xA5 to TXDATA → `uart_tx` waveform is 0 ×4, then bits 1,0,1,0,0,1,0,1 ×4 each, then 1 ×4 (40 cycles). STATUS busy=1 throughout, 0 after.
- Six back-to-back TXDATA stores of 0x01..0x06 → first byte popped; with 4 entries filling, the sixth store is dropped and STATUS=0x7. Bytes 01..05 are emitted in order. Store 0x4 to STATUS → overflow cleared.
- Assert reset mid-DATA of byte 0x3C → `uart_tx`=1 on the next cycle, FIFO empty, STATUS=0, no further frames.
